// File: rtl/ibuf2ddr.sv
// ibuf2ddr: reads N entries from one PE index buffer,
// packs them into DDR-width words and streams them out.
module ibuf2ddr #(
    parameter int IDX_DEPTH = 256,
    parameter int ADDR_W    = $clog2(IDX_DEPTH),
    parameter int PE_NUM    = 32,
    parameter int PE_W      = $clog2(PE_NUM),
    parameter int RD_LAT    = 1,
    parameter int DDR_W     = 64,
    parameter int IDX_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                conf_valid,
    output logic                conf_ready,
    input  logic [3:0]          conf_mode,
    input  logic [7:0]          conf_idx_num,
    input  logic [PE_W-1:0]     conf_pe_sel,
    output logic [PE_NUM-1:0]   idx_rd_en,
    output logic [ADDR_W-1:0]   idx_rd_addr,
    input  logic [2*IDX_W-1:0]  idx_rd_data,
    output logic [DDR_W-1:0]    ddr_data,
    output logic                ddr_valid,
    input  logic                ddr_ready,
    output logic                ddr_last
);

    localparam int B      = DDR_W / IDX_W / 2;
    localparam int SLOT_W = (B > 1) ? $clog2(B) : 1;
    localparam int CNT_W  = SLOT_W + 1;
    localparam int EW     = 2 * IDX_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_READ = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_SEND = 2'd3;

    logic [1:0]        r_state;
    logic              r_swap;
    logic [7:0]        r_remain;
    logic [PE_W-1:0]   r_pe_sel;
    logic [ADDR_W-1:0] r_addr;
    logic [CNT_W-1:0]  r_batch;
    logic [CNT_W-1:0]  r_issued;
    logic [CNT_W-1:0]  r_cap;
    logic [RD_LAT-1:0] r_vpipe;
    logic [DDR_W-1:0]  r_pack;
    logic [DDR_W-1:0]  r_ddr_data;
    logic              r_ddr_valid;
    logic              r_ddr_last;
    logic              r_conf_ready;

    logic              w_issue;
    logic              w_capture;
    logic              w_last_cap;
    logic              w_hs;
    logic [EW-1:0]     w_entry;
    logic [DDR_W-1:0]  w_pack_nxt;
    logic [7:0]        w_src;
    logic [CNT_W-1:0]  w_batch_nxt;
    logic              w_unused_ok;

    assign w_unused_ok = &{1'b0, conf_mode[3], conf_mode[0]};

    assign w_issue    = (r_state == S_READ) && (r_batch != '0);
    assign w_capture  = r_vpipe[RD_LAT-1];
    assign w_last_cap = w_capture && (r_cap == r_batch - CNT_W'(1));
    assign w_hs       = r_ddr_valid && ddr_ready;

    assign w_entry = r_swap
        ? {idx_rd_data[IDX_W-1:0], idx_rd_data[EW-1:IDX_W]}
        : idx_rd_data;

    // batch size for the next READ: min(B, entries still to read)
    assign w_src       = (r_state == S_IDLE) ? conf_idx_num : r_remain;
    assign w_batch_nxt = (w_src >= 8'(B)) ? CNT_W'(B) : w_src[CNT_W-1:0];

    assign idx_rd_en   = w_issue ? (PE_NUM'(1) << r_pe_sel) : '0;
    assign idx_rd_addr = r_addr;
    assign ddr_data    = r_ddr_data;
    assign ddr_valid   = r_ddr_valid;
    assign ddr_last    = r_ddr_last;
    assign conf_ready  = r_conf_ready;

    // merge the returning entry into its slot of the pack word
    always_comb begin
        w_pack_nxt = r_pack;
        if (w_capture) begin
            w_pack_nxt[int'(r_cap[SLOT_W-1:0]) * EW +: EW] = w_entry;
        end
    end

    // track which issued reads return data on the current cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            r_vpipe <= '0;
        end else begin
            r_vpipe[0] <= w_issue;
            for (int i = 1; i < RD_LAT; i++) begin
                r_vpipe[i] <= r_vpipe[i-1];
            end
        end
    end

    // control FSM, counters, pack register and output word
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_swap       <= 1'b0;
            r_remain     <= '0;
            r_pe_sel     <= '0;
            r_addr       <= '0;
            r_batch      <= '0;
            r_issued     <= '0;
            r_cap        <= '0;
            r_pack       <= '0;
            r_ddr_data   <= '0;
            r_ddr_valid  <= 1'b0;
            r_ddr_last   <= 1'b0;
            r_conf_ready <= 1'b1;
        end else begin
            if (w_capture) begin
                r_pack <= w_pack_nxt;
                r_cap  <= r_cap + CNT_W'(1);
            end
            case (r_state)
                S_IDLE: begin
                    if (conf_valid && r_conf_ready) begin
                        r_swap       <= (conf_mode[2:1] == 2'b01);
                        r_remain     <= conf_idx_num;
                        r_pe_sel     <= conf_pe_sel;
                        r_addr       <= '0;
                        r_batch      <= w_batch_nxt;
                        r_issued     <= '0;
                        r_cap        <= '0;
                        r_pack       <= '0;
                        r_conf_ready <= 1'b0;
                        r_state      <= S_READ;
                    end
                end
                S_READ: begin
                    if (r_batch == '0) begin
                        r_conf_ready <= 1'b1;
                        r_state      <= S_IDLE;
                    end else begin
                        // hold the address at N-1 after the final issue
                        if (r_remain > 8'd1) begin
                            r_addr <= r_addr + ADDR_W'(1);
                        end
                        r_remain <= r_remain - 8'd1;
                        r_issued <= r_issued + CNT_W'(1);
                        if (r_issued == r_batch - CNT_W'(1)) begin
                            r_state <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (w_last_cap) begin
                        r_ddr_data  <= w_pack_nxt;
                        r_ddr_valid <= 1'b1;
                        r_ddr_last  <= (r_remain == 8'd0);
                        r_state     <= S_SEND;
                    end
                end
                default: begin
                    if (w_hs) begin
                        r_ddr_valid <= 1'b0;
                        r_ddr_last  <= 1'b0;
                        if (r_remain != 8'd0) begin
                            r_batch  <= w_batch_nxt;
                            r_issued <= '0;
                            r_cap    <= '0;
                            r_pack   <= '0;
                            r_state  <= S_READ;
                        end else begin
                            r_conf_ready <= 1'b1;
                            r_state      <= S_IDLE;
                        end
                    end
                end
            endcase
        end
    end

endmodule
